spi_master_px: RTL and testbench

Parametrised successor to the fixed 8-bit, mode-0, divide-by-4 SPI master. It adds:
- configurable word width and SCK divider;
- runtime CPOL/CPHA/bit-order selection;
- programmable CS setup/hold;
- valid/ready streaming that keeps cs_n low across multi-word frames.

It sits between a command sequencer (e.g. the flash controller) and the SPI pins, and replaces register-mapped polling with a handshake.

---
 rtl/spi_master_px.sv | 191 +++++++++++++++++++
 tb/tb_spi_master_px.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_px.sv
// SPI master with configurable word width, SCK divider, CS setup/hold and runtime CPOL/CPHA/bit order.
// Latency: CS_SETUP + 2*DATA_W*CLK_DIV cycles from first accept to rx_valid; later words in a frame add 1 cycle.
// Backpressure: tx_ready is high only in IDLE/WAIT; rx_valid is a single-cycle pulse and cannot be stalled.
module spi_master_px #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W  = $clog2(2 * DATA_W);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WAIT, S_HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   shift_tx;
  logic [DATA_W-1:0]   shift_rx;
  logic                cpol_l;
  logic                cpha_l;
  logic                lsb_l;
  logic                last_l;

  logic                accept;
  logic                mode_cpha;
  logic                mode_lsb;
  logic                div_wrap;
  logic                lead_edge;
  logic                final_edge;
  logic [DATA_W-1:0]   load_word;
  logic [DATA_W-1:0]   next_rx;
  logic [DATA_W-1:0]   rx_word;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  // Mode bits come straight from the pins on an IDLE accept and from the latched copy mid-frame.
  assign accept     = tx_valid & tx_ready;
  assign mode_cpha  = (state == S_IDLE) ? cpha : cpha_l;
  assign mode_lsb   = (state == S_IDLE) ? lsb_first : lsb_l;
  assign load_word  = mode_lsb ? bit_rev(tx_data) : tx_data;
  assign next_rx    = {shift_rx[DATA_W-2:0], miso};
  assign div_wrap   = (div_cnt == DIV_LAST);
  assign lead_edge  = ~edge_cnt[0];
  assign final_edge = (edge_cnt == EDGE_LAST);
  // With cpha=1 the last sample lands on the final edge itself, so it is folded in here.
  assign rx_word    = cpha_l ? next_rx : shift_rx;

  // Frame sequencer: owns every output so cs_n/sck/mosi never glitch.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      last_l   <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cs_n     <= 1'b1;
          sck      <= cpol;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          if (accept) begin
            cpol_l   <= cpol;
            cpha_l   <= cpha;
            lsb_l    <= lsb_first;
            last_l   <= tx_last;
            shift_tx <= cpha ? load_word : (load_word << 1);
            if (!cpha) mosi <= load_word[DATA_W-1];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= S_XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (div_wrap) begin
            div_cnt  <= '0;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + 1'b1;
            if (lead_edge) begin
              if (!cpha_l) begin
                shift_rx <= next_rx;
              end else begin
                mosi     <= shift_tx[DATA_W-1];
                shift_tx <= shift_tx << 1;
              end
            end else begin
              if (cpha_l) begin
                shift_rx <= next_rx;
              end else if (!final_edge) begin
                mosi     <= shift_tx[DATA_W-1];
                shift_tx <= shift_tx << 1;
              end
            end
            if (final_edge) begin
              rx_valid <= 1'b1;
              rx_data  <= lsb_l ? bit_rev(rx_word) : rx_word;
              cnt      <= '0;
              if (last_l) begin
                state <= S_HOLD;
              end else begin
                tx_ready <= 1'b1;
                state    <= S_WAIT;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (accept) begin
            last_l   <= tx_last;
            shift_tx <= mode_cpha ? load_word : (load_word << 1);
            if (!mode_cpha) mosi <= load_word[DATA_W-1];
            tx_ready <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= S_XFER;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_px.sv
// Self-checking bench for spi_master_px (DATA_W=8, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2).
// A small slave model loops mosi back or replays a fixed reply word, MSB first.
// Received words are scoreboarded; frame timing is measured at the falling clock edge.
module tb_spi_master_px;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       cpol      = 1'b0;
  logic       cpha      = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_last   = 1'b0;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  spi_master_px #(.DATA_W(8), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic       loop_en  = 1'b1;
  logic [7:0] reply    = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       sck_prev = 1'b0;
  int         bit_idx  = 0;
  int         samp_total = 0;

  assign miso = loop_en ? mosi : reply[3'(7 - (bit_idx % 8))];

  // Sample edge is rising when cpol==cpha, falling otherwise; the slave advances after each one.
  always @(sck or cs_n) begin
    if (cs_n === 1'b1) begin
      bit_idx = 0;
    end else if (sck !== sck_prev && sck === (cpol ~^ cpha)) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      bit_idx  = bit_idx + 1;
      samp_total++;
    end
    sck_prev = sck;
  end

  // ---------------- monitor + scoreboard ----------------
  logic [7:0] sb[$];
  int cyc = 0, cs_low_total = 0, rdy_low_total = 0, rx_total = 0;
  int last_sck_cyc = 0, cs_rise_cyc = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1;
  logic [7:0] exp_rx;

  always @(negedge sys_clk) begin
    cyc++;
    if (cs_n === 1'b0) cs_low_total++;
    if (tx_ready === 1'b1 && cs_n === 1'b0) rdy_low_total++;
    if (sck !== prev_sck) last_sck_cyc = cyc;
    if (cs_n === 1'b1 && prev_cs === 1'b0) cs_rise_cyc = cyc;
    prev_sck = sck;
    prev_cs  = cs_n;
    if (sys_rst === 1'b0 && rx_valid === 1'b1) begin
      rx_total++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
      end else begin
        exp_rx = sb.pop_front();
        if (rx_data !== exp_rx) begin
          failures++;
          $display("FAIL rx_data actual=%0h required=%0h", rx_data, exp_rx);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge; returns at the falling edge following the accept.
  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp, input logic expect_rx);
    int n = 0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    if (expect_rx) sb.push_back(exp);
    @(negedge sys_clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cs_n !== 1'b1 || busy !== 1'b0) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("frame_done", {30'd0, cs_n, busy}, 32'h2);
    repeat (2) @(negedge sys_clk);
  endtask

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic       loop;
    logic [7:0] data;
    logic [7:0] reply;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int cs0, s0, r0;
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
    loop_en = v.loop; reply = v.reply;
    repeat (3) @(negedge sys_clk);
    cs0 = cs_low_total; s0 = samp_total; r0 = rx_total;
    send(v.data, 1'b1, v.exp_rx, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    chk($sformatf("vec%0d_rx_pulses", idx), rx_total - r0, 1);
    chk($sformatf("vec%0d_sample_edges", idx), samp_total - s0, 8);
    chk($sformatf("vec%0d_mosi_bits", idx), {24'd0, mosi_cap}, {24'd0, v.exp_mosi});
    chk($sformatf("vec%0d_cs_low_cycles", idx), cs_low_total - cs0, 36);
    chk($sformatf("vec%0d_sck_idle", idx), {31'd0, sck}, {31'd0, v.cpol});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cs0, s0, r0, rl0, n, bad;

    vecs[0] = '{cpol:1'b0, cpha:1'b0, lsb:1'b0, loop:1'b1, data:8'hA5, reply:8'h00, exp_rx:8'hA5, exp_mosi:8'hA5};
    vecs[1] = '{cpol:1'b1, cpha:1'b1, lsb:1'b0, loop:1'b0, data:8'hFF, reply:8'h3C, exp_rx:8'h3C, exp_mosi:8'hFF};
    vecs[2] = '{cpol:1'b0, cpha:1'b0, lsb:1'b1, loop:1'b1, data:8'h01, reply:8'h00, exp_rx:8'h01, exp_mosi:8'h80};
    vecs[3] = '{cpol:1'b0, cpha:1'b1, lsb:1'b0, loop:1'b0, data:8'h96, reply:8'h5A, exp_rx:8'h5A, exp_mosi:8'h96};
    vecs[4] = '{cpol:1'b1, cpha:1'b0, lsb:1'b1, loop:1'b1, data:8'hC1, reply:8'h00, exp_rx:8'hC1, exp_mosi:8'h83};
    vecs[5] = '{cpol:1'b1, cpha:1'b1, lsb:1'b1, loop:1'b0, data:8'h0F, reply:8'h12, exp_rx:8'h48, exp_mosi:8'hF0};

    // Reset values
    repeat (2) @(negedge sys_clk);
    chk("rst_cs_n", {31'd0, cs_n}, 1);
    chk("rst_sck", {31'd0, sck}, 0);
    chk("rst_mosi", {31'd0, mosi}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    sys_rst = 1'b0;
    #1;
    chk("rdy_before_first_edge", {31'd0, tx_ready}, 0);
    @(posedge sys_clk);
    #1;
    chk("rdy_after_first_edge", {31'd0, tx_ready}, 1);
    @(negedge sys_clk);

    // Single-word frames across modes and bit orders
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Three-word frame, tx_valid held throughout
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    cs0 = cs_low_total; s0 = samp_total; r0 = rx_total; rl0 = rdy_low_total;
    send(8'h11, 1'b0, 8'h11, 1'b1);
    send(8'h22, 1'b0, 8'h22, 1'b1);
    send(8'h33, 1'b1, 8'h33, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    // 2 setup + 3*32 transfer + 2 one-cycle WAIT gaps + 2 hold
    chk("multi_cs_low_cycles", cs_low_total - cs0, 102);
    chk("multi_rx_pulses", rx_total - r0, 3);
    chk("multi_sample_edges", samp_total - s0, 24);
    chk("multi_ready_in_wait", rdy_low_total - rl0, 2);
    chk("multi_cs_hold", cs_rise_cyc - last_sck_cyc, 2);
    chk("multi_last_mosi", {24'd0, mosi_cap}, 32'h33);

    // Reset in the middle of a word
    repeat (3) @(negedge sys_clk);
    r0 = rx_total; s0 = samp_total;
    send(8'hA5, 1'b1, 8'h00, 1'b0);
    tx_valid = 1'b0;
    n = 0;
    while (samp_total - s0 < 3 && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("abort_bits_before_reset", samp_total - s0, 3);
    sys_rst = 1'b1;
    #1;
    chk("abort_cs_n", {31'd0, cs_n}, 1);
    chk("abort_sck", {31'd0, sck}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_tx_ready", {31'd0, tx_ready}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("abort_no_rx", rx_total - r0, 0);
    run_vec(vecs[0], 6);

    // Upstream stalls for 10 cycles in WAIT
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; loop_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    cs0 = cs_low_total; r0 = rx_total;
    send(8'h5A, 1'b0, 8'h5A, 1'b1);
    tx_valid = 1'b0;
    n = 0;
    while (!(tx_ready === 1'b1 && cs_n === 1'b0) && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("stall_reached_wait", {30'd0, tx_ready, cs_n}, 32'h2);
    bad = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (cs_n !== 1'b0 || sck !== 1'b1 || tx_ready !== 1'b1) bad++;
    end
    chk("stall_wait_levels_bad", bad, 0);
    send(8'hC3, 1'b1, 8'hC3, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    // 2 setup + 32 + 11 WAIT cycles + 32 + 2 hold
    chk("stall_cs_low_cycles", cs_low_total - cs0, 79);
    chk("stall_rx_pulses", rx_total - r0, 2);
    chk("stall_mosi", {24'd0, mosi_cap}, 32'hC3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
